// File: rtl/nmi_pulse_gen.sv
// nmi_pulse_gen: turns the NMI counter's level into the active-low NMI pulse
// sampled by the 6502 core. The pulse is stretched to PULSE_CYCLES CPU clock enables.
// The self-test switch (test_n) qualifies it. Each NMI edge also feeds an optional watchdog.
//
// Build option: define WATCHDOG_EN to compile in the watchdog (wcnt/rcnt/WRST).
// Without it, wdog_rst is tied low and wdog_clr is ignored.

module nmi_pulse_gen #(
  parameter int unsigned PULSE_CYCLES = 8,
  parameter int unsigned WDOG_LIMIT   = 8,
  parameter int unsigned RST_CYCLES   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic nmi_in,
  input  logic cpu_ce,
  input  logic test_n,
  input  logic wdog_clr,
  output logic nmi_n,
  output logic wdog_rst
);

  localparam logic [7:0] PulseLoad = 8'(PULSE_CYCLES);

  typedef enum logic [0:0] {
    StIdle,
    StAssert
  } nmi_state_e;

  nmi_state_e state_q, state_d;
  logic [7:0] pcnt_q, pcnt_d;
  logic       nmi_q, nmi_d;
  logic       nmi_n_q, nmi_n_d;

  logic       nmi_edge;
  logic       wrst_active;  // watchdog reset currently being held
  logic       wrst_enter;   // this clk's edge trips the watchdog

  // nmi_q resets high so a level already high at reset release is not an edge.
  assign nmi_d    = nmi_in;
  assign nmi_edge = nmi_in & ~nmi_q;

`ifdef WATCHDOG_EN
  localparam logic [7:0] WdogLimit = 8'(WDOG_LIMIT);
  localparam logic [7:0] RstLoad   = 8'(RST_CYCLES);

  logic [7:0] wcnt_q, wcnt_d;
  logic [7:0] rcnt_q, rcnt_d;
  logic       wdog_rst_q, wdog_rst_d;

  // Watchdog next state: count edges, trip at the limit, then time the reset.
  always_comb begin
    wcnt_d     = wcnt_q;
    rcnt_d     = rcnt_q;
    wdog_rst_d = wdog_rst_q;
    wrst_enter = 1'b0;
    if (wdog_rst_q) begin
      // Edges and clears are ignored while the reset is held.
      if (cpu_ce) begin
        if (rcnt_q == 8'd1) begin
          rcnt_d     = 8'd0;
          wdog_rst_d = 1'b0;
        end else begin
          rcnt_d = rcnt_q - 8'd1;
        end
      end
    end else if (wdog_clr) begin
      // Clear wins over a coincident edge.
      wcnt_d = 8'd0;
    end else if (nmi_edge) begin
      if (wcnt_q + 8'd1 == WdogLimit) begin
        wcnt_d     = 8'd0;
        rcnt_d     = RstLoad;
        wdog_rst_d = 1'b1;
        wrst_enter = 1'b1;
      end else begin
        wcnt_d = wcnt_q + 8'd1;
      end
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q     <= 8'd0;
      rcnt_q     <= 8'd0;
      wdog_rst_q <= 1'b0;
    end else begin
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      wdog_rst_q <= wdog_rst_d;
    end
  end

  assign wrst_active = wdog_rst_q;
  assign wdog_rst    = wdog_rst_q;
`else
  logic unused_wdog;
  assign unused_wdog = ^{wdog_clr, 8'(WDOG_LIMIT), 8'(RST_CYCLES)};

  assign wrst_active = 1'b0;
  assign wrst_enter  = 1'b0;
  assign wdog_rst    = 1'b0;
`endif

  // NMI FSM next state: start a pulse on a qualified edge, stretch over cpu_ce.
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    nmi_n_d = nmi_n_q;
    if (wrst_active || wrst_enter) begin
      // A watchdog reset overrides any pulse in flight.
      state_d = StIdle;
      pcnt_d  = 8'd0;
      nmi_n_d = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          nmi_n_d = 1'b1;
          if (nmi_edge && test_n) begin
            state_d = StAssert;
            pcnt_d  = PulseLoad;
            nmi_n_d = 1'b0;
          end
        end
        StAssert: begin
          // Further edges and test_n changes do not affect a running pulse.
          nmi_n_d = 1'b0;
          if (cpu_ce) begin
            if (pcnt_q == 8'd1) begin
              state_d = StIdle;
              pcnt_d  = 8'd0;
              nmi_n_d = 1'b1;
            end else begin
              pcnt_d = pcnt_q - 8'd1;
            end
          end
        end
        default: begin
          state_d = StIdle;
          pcnt_d  = 8'd0;
          nmi_n_d = 1'b1;
        end
      endcase
    end
  end

  // NMI FSM, pulse counter, edge detector and registered nmi_n.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pcnt_q  <= 8'd0;
      nmi_q   <= 1'b1;
      nmi_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      nmi_q   <= nmi_d;
      nmi_n_q <= nmi_n_d;
    end
  end

  assign nmi_n = nmi_n_q;

endmodule

// File: tb/tb_nmi_pulse_gen.sv
// Bench for nmi_pulse_gen: a fixed vector table, directed multi-cycle sequences and
// random stimulus, all checked against an event-level reference model.

module tb_nmi_pulse_gen;

  localparam int unsigned PulseCycles = 8;
  localparam int unsigned WdogLimit   = 8;
  localparam int unsigned RstCycles   = 16;

`ifdef WATCHDOG_EN
  localparam bit WdogOn = 1'b1;
`else
  localparam bit WdogOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, nmi_in, cpu_ce, test_n, wdog_clr;
  logic nmi_n, wdog_rst;

  always #5 clk = ~clk;

  nmi_pulse_gen #(
    .PULSE_CYCLES(PulseCycles),
    .WDOG_LIMIT  (WdogLimit),
    .RST_CYCLES  (RstCycles)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .nmi_in  (nmi_in),
    .cpu_ce  (cpu_ce),
    .test_n  (test_n),
    .wdog_clr(wdog_clr),
    .nmi_n   (nmi_n),
    .wdog_rst(wdog_rst)
  );

  int vectors     = 0;
  int miscompares = 0;
  int ce_phase    = 0;

  // Reference model: enables still owed to the NMI pulse, uncleared edge count,
  // enables still owed to the watchdog reset, previous nmi_in level.
  int   m_pulse_left = 0;
  int   m_edges      = 0;
  int   m_reset_left = 0;
  logic m_prev       = 1'b1;

  task automatic model_step();
    bit edge_seen;
    bit tripped;
    edge_seen = nmi_in && !m_prev;
    tripped   = 1'b0;
    if (rst) begin
      m_pulse_left = 0;
      m_edges      = 0;
      m_reset_left = 0;
      m_prev       = 1'b1;
    end else begin
      if (m_reset_left > 0) begin
        if (cpu_ce) m_reset_left--;
        m_pulse_left = 0;
      end else begin
        if (WdogOn) begin
          if (wdog_clr) m_edges = 0;
          else if (edge_seen) begin
            m_edges++;
            if (m_edges == int'(WdogLimit)) begin
              m_edges      = 0;
              m_reset_left = RstCycles;
              tripped      = 1'b1;
            end
          end
        end
        if (tripped) m_pulse_left = 0;
        else if (m_pulse_left > 0) begin
          if (cpu_ce) m_pulse_left--;
        end else if (edge_seen && test_n) m_pulse_left = PulseCycles;
      end
      m_prev = nmi_in;
    end
  endtask

  task automatic check(input string name, input logic exp_nmi_n, input logic exp_wdog);
    vectors++;
    if (nmi_n !== exp_nmi_n || wdog_rst !== exp_wdog) begin
      miscompares++;
      $display("FAIL %s @%0t: got nmi_n=%b wdog_rst=%b, expected nmi_n=%b wdog_rst=%b",
               name, $time, nmi_n, wdog_rst, exp_nmi_n, exp_wdog);
    end
  endtask

  // One clk with the current inputs; compare against the model 1 time unit after the edge.
  task automatic tick(input string name);
    @(posedge clk);
    model_step();
    #1;
    check(name, logic'(m_pulse_left == 0), logic'(m_reset_left > 0));
  endtask

  // Run n clks with cpu_ce every 4th clk.
  task automatic run(input string name, input logic n, input logic t, input logic clr,
                     input int cycles);
    for (int i = 0; i < cycles; i++) begin
      rst      = 1'b0;
      nmi_in   = n;
      test_n   = t;
      wdog_clr = clr;
      cpu_ce   = (ce_phase % 4 == 3);
      ce_phase++;
      tick(name);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    nmi_in   = 1'b0;
    cpu_ce   = 1'b0;
    test_n   = 1'b1;
    wdog_clr = 1'b0;
    ce_phase = 0;
    tick("reset");
    tick("reset");
  endtask

  // One NMI level pulse: rise for hi clks, fall for lo clks.
  task automatic nmi_pulse(input string name, input logic t, input logic clr_on_rise,
                           input int hi, input int lo);
    run(name, 1'b1, t, clr_on_rise, 1);
    run(name, 1'b1, t, 1'b0, hi - 1);
    run(name, 1'b0, t, 1'b0, lo);
  endtask

  typedef struct packed {
    logic rst;
    logic nmi_in;
    logic cpu_ce;
    logic test_n;
    logic wdog_clr;
    logic exp_nmi_n;
    logic exp_wdog;
  } vec_t;

  vec_t tbl[19];

  initial begin
    rst      = 1'b1;
    nmi_in   = 1'b1;
    cpu_ce   = 1'b0;
    test_n   = 1'b1;
    wdog_clr = 1'b0;

    //              rst   nmi   ce    tn    clr   nmi_n wdog
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};  // reset, nmi_in high
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};  // no edge at release
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};  // edge; its ce not counted
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};  // ce 1
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};  // ce 2
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};  // ce 3
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};  // ce 4, re-edge ignored
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};  // ce 5
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};  // ce 6, test_n low no abort
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};  // ce 7
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};  // ce 8 ends pulse
    tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};  // no second pulse
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};  // suppressed edge
    tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < 19; i++) begin
      rst      = tbl[i].rst;
      nmi_in   = tbl[i].nmi_in;
      cpu_ce   = tbl[i].cpu_ce;
      test_n   = tbl[i].test_n;
      wdog_clr = tbl[i].wdog_clr;
      @(posedge clk);
      model_step();
      #1;
      check($sformatf("table[%0d]", i), tbl[i].exp_nmi_n, tbl[i].exp_wdog);
    end

    // Single NMI with cpu_ce every 4 clk.
    do_reset();
    run("single_idle", 1'b0, 1'b1, 1'b0, 5);
    nmi_pulse("single_nmi", 1'b1, 1'b0, 6, 40);

    // Self-test suppression, then enough live edges to show the suppressed ones counted.
    do_reset();
    for (int i = 0; i < 3; i++) nmi_pulse("suppress", 1'b0, 1'b0, 3, 5);
    for (int i = 0; i < 6; i++) nmi_pulse("suppress_then_live", 1'b1, 1'b0, 3, 40);
    run("suppress_tail", 1'b0, 1'b1, 1'b0, 80);

    // Re-trigger 3 cpu_ce into a pulse (ce at clk 3, 7, 11 of the phase).
    do_reset();
    run("retrig_pre", 1'b0, 1'b1, 1'b0, 3);
    nmi_pulse("retrig_first", 1'b1, 1'b0, 4, 9);
    nmi_pulse("retrig_second", 1'b1, 1'b0, 4, 40);

    // Watchdog timeout: 8 uncleared edges.
    do_reset();
    for (int i = 0; i < 8; i++) nmi_pulse("wdog_timeout", 1'b1, 1'b0, 2, 4);
    run("wdog_hold", 1'b0, 1'b1, 1'b0, 90);

    // Clear collides with the 8th edge, then 8 more edges trip normally.
    do_reset();
    for (int i = 0; i < 7; i++) nmi_pulse("clr_pre", 1'b1, 1'b0, 2, 4);
    nmi_pulse("clr_collide", 1'b1, 1'b1, 2, 10);
    for (int i = 0; i < 7; i++) nmi_pulse("clr_after", 1'b1, 1'b0, 2, 4);
    run("clr_after_idle", 1'b0, 1'b1, 1'b0, 40);
    nmi_pulse("clr_trip", 1'b1, 1'b0, 2, 80);

    // Reset mid-pulse with nmi_in held high through reset.
    do_reset();
    run("rstmid_pre", 1'b0, 1'b1, 1'b0, 3);
    run("rstmid_pulse", 1'b1, 1'b1, 1'b0, 9);
    rst = 1'b1;
    tick("rstmid_reset");
    tick("rstmid_reset");
    run("rstmid_held", 1'b1, 1'b1, 1'b0, 20);
    nmi_pulse("rstmid_refire", 1'b0, 1'b1, 1, 1);
    nmi_pulse("rstmid_refire", 1'b1, 1'b0, 3, 40);

    // Random stimulus.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst      = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 5) == 0) nmi_in = ~nmi_in;
      cpu_ce   = ($urandom_range(0, 2) == 0);
      test_n   = ($urandom_range(0, 9) != 0);
      wdog_clr = ($urandom_range(0, 39) == 0);
      tick("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nmi_pulse_gen.md
# nmi_pulse_gen

Sits directly downstream of the 13-tick NMI counter and converts its NMI level into the active-low, edge-generated NMI pulse the 6502 core samples. The level is qualified by the self-test switch and stretched to a fixed number of CPU clock enables. Each NMI edge also advances a watchdog that resets the CPU if software stops servicing it.

## Interface
- PULSE_CYCLES, 8: number of cpu_ce enables nmi_n is held low per NMI (range 1..255).
- WDOG_LIMIT, 8: NMI edges allowed without wdog_clr before a watchdog reset (range 1..255).
- RST_CYCLES, 16: number of cpu_ce enables wdog_rst is held high (range 1..255).
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- nmi_in  in  1  NMI level from the NMI counter; high for one counter period.
- cpu_ce  in  1  CPU clock enable, one clk wide.
- test_n  in  1  self-test switch, active low; low suppresses NMI generation.
- wdog_clr  in  1  watchdog clear strobe (CPU write decode), one clk wide.
- nmi_n  out  1  NMI to CPU, active low, registered.
- wdog_rst  out  1  CPU reset request, active high, registered.

## Operation
- Edge detect: nmi_q <= nmi_in each clk; edge = nmi_in & ~nmi_q. nmi_q resets to 1, so no spurious edge if nmi_in is high at reset release.
- NMI FSM has 2 states, IDLE and ASSERT. The 8-bit pulse counter is pcnt.
- IDLE: nmi_n=1. On edge with test_n=1: load pcnt=PULSE_CYCLES and go to ASSERT. Edges with test_n=0 are discarded.
- ASSERT: nmi_n=0. On each cpu_ce, decrement pcnt. On cpu_ce with pcnt==1, go to IDLE.
- ASSERT: edges arriving here are ignored and do not extend the pulse. A change of test_n does not abort the pulse.
- Watchdog: 8-bit wcnt counts every edge, whether or not test_n is high.
- wdog_clr sets wcnt=0. If wdog_clr and edge occur in the same clk, the clear wins and wcnt=0.
- When an edge would make wcnt equal WDOG_LIMIT, enter WRST: wcnt=0, wdog_rst=1, and load rcnt=RST_CYCLES.
- WRST: decrement rcnt on each cpu_ce. On cpu_ce with rcnt==1, set wdog_rst=0.
- While in WRST, the NMI FSM is forced to IDLE (nmi_n=1), and both edges and wdog_clr are ignored.
- rst in any state: nmi_n=1, wdog_rst=0, FSM=IDLE, pcnt=0, wcnt=0, rcnt=0, nmi_q=1.

## Timing
- Reset values: nmi_n=1, wdog_rst=0.
- nmi_n falls on the clk edge following the edge-detect cycle, a latency of 1 clk after nmi_in rises.
- A cpu_ce in the edge-detect cycle does not count toward the pulse.
- nmi_n stays low through exactly PULSE_CYCLES cpu_ce pulses. It rises on the clk after the PULSE_CYCLES-th cpu_ce.
- wdog_rst rises 1 clk after the WDOG_LIMIT-th uncleared edge.
- wdog_rst falls 1 clk after the RST_CYCLES-th cpu_ce that follows its rise.
- All outputs are registered. There are no combinational paths from input to output.

## Configuration
- WATCHDOG_EN defined: the watchdog and the WRST behaviour are compiled in as described above.
- WATCHDOG_EN undefined: wcnt, rcnt and WRST are removed. wdog_rst is tied to 0, and wdog_clr is ignored. NMI behaviour is otherwise identical.

## Test plan
- Single NMI: defaults, test_n=1, cpu_ce every 4 clk, nmi_in pulsed high.
  - nmi_n low 1 clk after the rise, for exactly 8 cpu_ce, then high.
- Self-test suppression: test_n=0, three nmi_in pulses.
  - nmi_n stays 1 throughout.
  - With WATCHDOG_EN, wcnt reaches 3.
- Re-trigger: PULSE_CYCLES=8, second nmi_in rise arrives 3 cpu_ce into the pulse.
  - Pulse still ends after 8 cpu_ce from the first edge, and no second pulse follows.
- Watchdog timeout: WATCHDOG_EN, defaults, 8 edges with no wdog_clr.
  - wdog_rst=1 from 1 clk after the 8th edge for 16 cpu_ce, and nmi_n=1 during that time.
- Clear collision: wdog_clr asserted in the same clk as the 8th edge.
  - wcnt=0, and wdog_rst stays 0.
- Reset mid-pulse: rst asserted 2 cpu_ce into an NMI, with nmi_in held high through reset.
  - nmi_n=1 on the next clk, and no new pulse after release until nmi_in falls and rises again.
